mux_n_1_rr: RTL and testbench
=============================

# mux_n_1_rr

Parametrised N:1 data multiplexer, successor to the 2:1 combinational mux: selects one of NUM_CH input channels of WIDTH bits and presents it on a registered output with a valid/ready handshake. Channel choice comes from either an explicit `select` input (fixed mode) or an internal round-robin arbiter (round-robin mode). It sits between multiple producer streams and a single consumer.

## Interface
- `WIDTH`, 8: data width per channel, ≥1.
- `NUM_CH`, 4: number of input channels, ≥2.
- `SEL_W` (localparam) = $clog2(NUM_CH): width of `select` and `y_ch`.

- `clk`  in  1  rising-edge clock, the block's only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `a`  in  NUM_CH*WIDTH  packed channel data; channel i at bits [i*WIDTH +: WIDTH].
- `a_valid`  in  NUM_CH  per-channel valid.
- `a_ready`  out  NUM_CH  per-channel ready (combinational).
- `mode`  in  1  0 = fixed (use `select`), 1 = round-robin.
- `select`  in  SEL_W  channel index in fixed mode.
- `y`  out  WIDTH  registered output data.
- `y_valid`  out  1  output holds a word.
- `y_ready`  in  1  consumer accepts `y` this cycle.
- `y_ch`  out  SEL_W  index of the channel that supplied `y`.

## Operation
- Single output register stage. `load_en = !y_valid || y_ready`.
- Grant (combinational, at most one-hot):
  - Fixed mode: grant channel `select` iff `select < NUM_CH` and `a_valid[select]`; otherwise no grant. An out-of-range `select` never grants.
  - Round-robin mode: search channels starting at `(rr_ptr+1) mod NUM_CH`, wrapping, and grant the first with `a_valid` set. No valid channel means no grant.
- `a_ready[i] = grant[i] && load_en && !rst`. All other `a_ready` bits are 0.
- Transfer on channel i: `a_valid[i] && a_ready[i]`. On the next edge `y` ← channel i data, `y_ch` ← i, `y_valid` ← 1.
- Drain without a new grant (`y_valid && y_ready`, no transfer): `y_valid` ← 0. `y` and `y_ch` hold their values.
- Stall (`y_valid && !y_ready`): `y`, `y_ch` and `y_valid` hold; all `a_ready` = 0.
- `rr_ptr` updates to i only on a transfer from channel i, in either mode. Fixed-mode transfers therefore also advance the round-robin position.
- `mode` and `select` are sampled combinationally each cycle. A change affects the grant in the same cycle and never corrupts a word already in `y`.
- Producers must hold data stable while valid and not ready. The block does not check this.

## Timing
- Reset (edge with `rst`=1): `y`=0, `y_valid`=0, `y_ch`=0, `rr_ptr`=NUM_CH-1, so channel 0 has first round-robin priority. `a_ready`=0 throughout reset.
- Latency: 1 cycle from input transfer to `y_valid`.
- Throughput: 1 word/cycle when `y_ready` is held high (simultaneous drain and load).
- Round-robin fairness: with all channels valid, grants rotate 0,1,…,NUM_CH-1,0,…, one per accepted transfer.
- Reset mid-operation: any word in `y` is discarded. No input transfer occurs on the reset edge.
- Simultaneous valid on several channels: exactly one is granted. Non-granted producers see ready=0 and must hold.

## Test plan
- Reset: WIDTH=8, NUM_CH=4; assert `rst` for 2 cycles while `a_valid`=4'b1111 → `y`=0, `y_valid`=0, `y_ch`=0, `a_ready`=0; after release the first grant goes to ch0.
- Fixed mode: `mode`=0, `select`=2, ch2 data 8'hA5 valid, `y_ready`=1 → `a_ready`=4'b0100, next cycle `y`=8'hA5, `y_ch`=2; then `select`=5 (SEL_W=3 with NUM_CH=5, ch4 max) → no grant.
- Round-robin: `mode`=1, all four valid with data 8'h10/11/12/13, `y_ready`=1 → `y` sequence 10,11,12,13,10 on consecutive cycles, `y_ch` 0,1,2,3,0.
- Sparse round-robin: only ch1 and ch3 valid → grants alternate 1,3,1,3. Then ch3 drops → ch1 granted every cycle.
- Backpressure: `y_ready`=0 with `y_valid`=1 for 3 cycles → `y` and `y_ch` stable, `a_ready`=0. Raise `y_ready` → next word loads on the same edge as the drain.
- Reset mid-stream: assert `rst` while `y_valid`=1 and `y_ready`=0 → next cycle `y_valid`=0 and `rr_ptr` restarts, so the first post-reset grant is ch0.

Source files
------------

// File: rtl/mux_n_1_rr_if.sv
// Handshake and data bundle for mux_n_1_rr: NUM_CH producer channels feeding
// one consumer, plus the channel-selection controls.
// The slave modport is the multiplexer's view. The master modport is the view
// of whatever drives the producers and the consumer.
interface mux_n_1_rr_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4
);
    localparam int SEL_W = $clog2(NUM_CH);

    logic [NUM_CH*WIDTH-1:0] a;
    logic [NUM_CH-1:0]       a_valid;
    logic [NUM_CH-1:0]       a_ready;
    logic                    mode;
    logic [SEL_W-1:0]        select;
    logic [WIDTH-1:0]        y;
    logic                    y_valid;
    logic                    y_ready;
    logic [SEL_W-1:0]        y_ch;

    modport slave (
        input  a, a_valid, mode, select, y_ready,
        output a_ready, y, y_valid, y_ch
    );

    modport master (
        output a, a_valid, mode, select, y_ready,
        input  a_ready, y, y_valid, y_ch
    );
endinterface

// File: rtl/mux_n_1_rr.sv
// N:1 data multiplexer with a single registered output stage and a
// valid/ready handshake on both sides.
// mode=0 takes the channel index from select. An index at or above NUM_CH
// never grants.
// mode=1 uses a round-robin search that starts one past the last channel
// that transferred.
// The round-robin pointer follows every transfer, so fixed-mode traffic also
// moves the round-robin position.
// WIDTH and NUM_CH must match the parameters of the connected interface.
module mux_n_1_rr #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4
) (
    input  logic          clk,
    input  logic          rst,
    mux_n_1_rr_if.slave   bus
);
    localparam int SEL_W = $clog2(NUM_CH);

    logic [WIDTH-1:0]  y_q,       y_d;
    logic              y_valid_q, y_valid_d;
    logic [SEL_W-1:0]  y_ch_q,    y_ch_d;
    logic [SEL_W-1:0]  rr_ptr_q,  rr_ptr_d;

    logic              load_en;
    logic [NUM_CH-1:0] grant_fix;
    logic [NUM_CH-1:0] grant_rr;
    logic [NUM_CH-1:0] grant;
    logic [NUM_CH-1:0] a_ready_int;
    logic              xfer;
    logic [SEL_W-1:0]  grant_idx;
    logic [WIDTH-1:0]  grant_data;

    // First valid channel after ptr, wrapping. The pointer's own channel is
    // checked last, so the last winner has the lowest priority.
    function automatic logic [NUM_CH-1:0] rr_pick(
        input logic [NUM_CH-1:0] valid,
        input logic [SEL_W-1:0]  ptr
    );
        logic [NUM_CH-1:0] g;
        logic              found;
        int                idx;
        g     = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(ptr) + k) % NUM_CH;
            if (!found && valid[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

    // The output stage can take a new word when it is empty or being drained
    assign load_en = !y_valid_q || bus.y_ready;

    // Fixed-mode grant. Comparing against each legal index means an
    // out-of-range select matches nothing.
    always_comb begin
        grant_fix = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(bus.select) == i) begin
                grant_fix[i] = bus.a_valid[i];
            end
        end
    end

    // Round-robin grant from the pointer of the last transfer
    always_comb begin
        grant_rr = rr_pick(bus.a_valid, rr_ptr_q);
    end

    // Mode is applied combinationally, so a change only affects who is
    // granted next. It never touches the word already held in y.
    always_comb begin
        grant = bus.mode ? grant_rr : grant_fix;
    end

    // Ready to the granted producer only. It is held low through reset so
    // that no transfer lands on a reset edge.
    always_comb begin
        a_ready_int = grant & {NUM_CH{load_en && !rst}};
    end

    assign bus.a_ready = a_ready_int;

    // Encode the one-hot grant and pick the matching channel data
    always_comb begin
        grant_idx  = '0;
        grant_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                grant_idx  = SEL_W'(i);
                grant_data = bus.a[i*WIDTH +: WIDTH];
            end
        end
    end

    // A granted channel is always valid, so any ready bit is a transfer
    assign xfer = |(a_ready_int & bus.a_valid);

    // Next state: load on transfer, otherwise empty on drain, otherwise hold
    always_comb begin
        y_d       = y_q;
        y_valid_d = y_valid_q;
        y_ch_d    = y_ch_q;
        rr_ptr_d  = rr_ptr_q;
        if (xfer) begin
            y_d       = grant_data;
            y_ch_d    = grant_idx;
            y_valid_d = 1'b1;
            rr_ptr_d  = grant_idx;
        end else if (bus.y_ready) begin
            y_valid_d = 1'b0;
        end
    end

    // State registers. Reset points rr_ptr at the last channel, so the first
    // round-robin search starts at channel 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
            y_ch_q    <= '0;
            rr_ptr_q  <= SEL_W'(NUM_CH - 1);
        end else begin
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            y_ch_q    <= y_ch_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;
    assign bus.y_ch    = y_ch_q;

endmodule

// File: tb/tb_mux_n_1_rr.sv
module tb_mux_n_1_rr;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_n_1_rr_if #(.WIDTH(8), .NUM_CH(4)) bus  ();
    mux_n_1_rr_if #(.WIDTH(8), .NUM_CH(5)) bus5 ();

    mux_n_1_rr #(.WIDTH(8), .NUM_CH(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
    mux_n_1_rr #(.WIDTH(8), .NUM_CH(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] ch;
    } exp_t;

    exp_t sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each word the consumer takes is compared with the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && bus.y_valid === 1'b1 && bus.y_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got y=%0h ch=%0d expected none", bus.y, bus.y_ch);
            end else begin
                e = sb_q.pop_front();
                chk("y_data", 32'(bus.y), 32'(e.d));
                chk("y_ch", 32'(bus.y_ch), 32'(e.ch));
            end
        end
    end

    task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
        bus.a = {d3, d2, d1, d0};
    endtask

    // Apply a_valid, check the combinational ready, optionally queue the
    // expected word, then move to just after the next rising edge
    task automatic cyc(input logic [3:0] v, input logic [3:0] exp_rdy,
                       input bit push, input logic [7:0] d, input logic [1:0] ch);
        bus.a_valid = v;
        #1;
        chk("a_ready", 32'(bus.a_ready), 32'(exp_rdy));
        if (push) sb_q.push_back({d, ch});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        bus.a_valid  = 4'b1111;
        bus.mode     = 1'b1;
        bus.select   = 2'd0;
        bus.y_ready  = 1'b1;
        set_data(8'h10, 8'h11, 8'h12, 8'h13);
        bus5.a       = {8'h44, 8'h43, 8'h42, 8'h41, 8'h40};
        bus5.a_valid = 5'b00000;
        bus5.mode    = 1'b0;
        bus5.select  = 3'd0;
        bus5.y_ready = 1'b1;

        // Reset held two cycles with every channel valid
        @(posedge clk); #1;
        chk("rst_a_ready", 32'(bus.a_ready), 32'h0);
        @(posedge clk); #1;
        chk("rst_a_ready2", 32'(bus.a_ready), 32'h0);
        chk("rst_y", 32'(bus.y), 32'h0);
        chk("rst_y_valid", 32'(bus.y_valid), 32'h0);
        chk("rst_y_ch", 32'(bus.y_ch), 32'h0);
        rst = 1'b0;

        // Round-robin with all four valid: 0,1,2,3,0
        cyc(4'b1111, 4'b0001, 1, 8'h10, 2'd0);
        cyc(4'b1111, 4'b0010, 1, 8'h11, 2'd1);
        cyc(4'b1111, 4'b0100, 1, 8'h12, 2'd2);
        cyc(4'b1111, 4'b1000, 1, 8'h13, 2'd3);
        cyc(4'b1111, 4'b0001, 1, 8'h10, 2'd0);
        cyc(4'b0000, 4'b0000, 0, 8'h00, 2'd0);
        chk("drained", 32'(bus.y_valid), 32'h0);

        // Fixed mode: unselected channel valid gives nothing, then select ch2
        bus.mode = 1'b0;
        bus.select = 2'd1;
        set_data(8'h00, 8'h00, 8'hA5, 8'h00);
        cyc(4'b0100, 4'b0000, 0, 8'h00, 2'd0);
        bus.select = 2'd2;
        cyc(4'b0100, 4'b0100, 1, 8'hA5, 2'd2);
        cyc(4'b0000, 4'b0000, 0, 8'h00, 2'd0);

        // Sparse round-robin: last transfer was ch2, so ch3 then ch1 alternate
        bus.mode = 1'b1;
        set_data(8'h00, 8'h21, 8'h00, 8'h23);
        cyc(4'b1010, 4'b1000, 1, 8'h23, 2'd3);
        cyc(4'b1010, 4'b0010, 1, 8'h21, 2'd1);
        cyc(4'b1010, 4'b1000, 1, 8'h23, 2'd3);
        cyc(4'b1010, 4'b0010, 1, 8'h21, 2'd1);
        cyc(4'b0010, 4'b0010, 1, 8'h21, 2'd1);
        cyc(4'b0010, 4'b0010, 1, 8'h21, 2'd1);
        cyc(4'b0000, 4'b0000, 0, 8'h00, 2'd0);

        // Backpressure: hold three cycles, then drain and load on one edge
        set_data(8'h30, 8'h31, 8'h32, 8'h33);
        cyc(4'b0001, 4'b0001, 1, 8'h30, 2'd0);
        bus.y_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(4'b1111, 4'b0000, 0, 8'h00, 2'd0);
            chk("stall_y", 32'(bus.y), 32'h30);
            chk("stall_y_ch", 32'(bus.y_ch), 32'h0);
            chk("stall_y_valid", 32'(bus.y_valid), 32'h1);
        end
        bus.y_ready = 1'b1;
        cyc(4'b1111, 4'b0010, 1, 8'h31, 2'd1);
        cyc(4'b0000, 4'b0000, 0, 8'h00, 2'd0);

        // Reset mid-stream discards the held word and restarts the pointer
        cyc(4'b0100, 4'b0100, 0, 8'h00, 2'd0);
        bus.y_ready = 1'b0;
        bus.a_valid = 4'b1111;
        #1;
        chk("pre_rst_y_valid", 32'(bus.y_valid), 32'h1);
        chk("pre_rst_y", 32'(bus.y), 32'h32);
        rst = 1'b1;
        #1;
        chk("in_rst_a_ready", 32'(bus.a_ready), 32'h0);
        @(posedge clk); #1;
        chk("post_rst_y_valid", 32'(bus.y_valid), 32'h0);
        chk("post_rst_y", 32'(bus.y), 32'h0);
        rst = 1'b0;
        bus.y_ready = 1'b1;
        cyc(4'b1111, 4'b0001, 1, 8'h30, 2'd0);
        cyc(4'b0000, 4'b0000, 0, 8'h00, 2'd0);

        // Five-channel instance: out-of-range selects never grant
        bus5.a_valid = 5'b11111;
        bus5.select = 3'd5;
        #1;
        chk("sel5_a_ready", 32'(bus5.a_ready), 32'h0);
        bus5.select = 3'd7;
        #1;
        chk("sel7_a_ready", 32'(bus5.a_ready), 32'h0);
        bus5.select = 3'd4;
        #1;
        chk("sel4_a_ready", 32'(bus5.a_ready), 32'h10);
        @(posedge clk); #1;
        bus5.a_valid = 5'b00000;
        chk("sel4_y", 32'(bus5.y), 32'h44);
        chk("sel4_y_ch", 32'(bus5.y_ch), 32'h4);
        chk("sel4_y_valid", 32'(bus5.y_valid), 32'h1);
        @(posedge clk); #1;

        // Every queued expectation must have been consumed by now
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
